// File: rtl/reg_w.sv
// ---------------------------------------------------------------------------
// reg_w : MEM -> WB pipeline register of the 5-stage MIPS CPU.
//
// Captures the memory-stage control bits, the data-memory read result, the
// ALU result and the destination register number on each rising clk edge.
// It presents them to the write-back stage one cycle later. There is no
// combinational path from any input to any output.
//
// Parameters
//   DATA_W      width of the read-data and ALU-result paths (default 32)
//   REG_ADDR_W  width of the destination register number  (default 5)
//
// Ports
//   clk           system clock, rising-edge capture
//   rst           asynchronous active-high reset; all outputs 0 (bubble)
//   stall_w       1 = hold every output at its current value
//   flush_w       (only with REG_W_FLUSH_EN) 1 = load a bubble at the edge,
//                 taking priority over stall_w
//   reg_write_m   -> reg_write_w    register-file write enable
//   mem_to_reg_m  -> mem_to_reg_w   write-back select (1 = memory data)
//   jal_m         -> jal_w          jump-and-link marker
//   read_data_m   -> read_data_w    data-memory read result
//   alu_out_m     -> alu_out_w      ALU result / memory address
//   write_reg_m   -> write_reg_w    destination register number
//
// Optional feature macro: REG_W_FLUSH_EN (adds flush_w).
// Register-0 write suppression is left to the register file; a write_reg_m
// of 0 is passed through untouched.
// ---------------------------------------------------------------------------
module reg_w #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stall_w,
`ifdef REG_W_FLUSH_EN
  input  logic                  flush_w,
`endif
  input  logic                  reg_write_m,
  input  logic                  mem_to_reg_m,
  input  logic                  jal_m,
  input  logic [DATA_W-1:0]     read_data_m,
  input  logic [DATA_W-1:0]     alu_out_m,
  input  logic [REG_ADDR_W-1:0] write_reg_m,
  output logic                  reg_write_w,
  output logic                  mem_to_reg_w,
  output logic                  jal_w,
  output logic [DATA_W-1:0]     read_data_w,
  output logic [DATA_W-1:0]     alu_out_w,
  output logic [REG_ADDR_W-1:0] write_reg_w
);

  // Flush is tied off in the default build so the priority chain below reads
  // the same in both configurations.
  logic flush;
`ifdef REG_W_FLUSH_EN
  assign flush = flush_w;
`else
  assign flush = 1'b0;
`endif

  // Priority: rst > flush > stall > capture. The all-zero state is a bubble
  // because reg_write_w = 0 means nothing is written back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reg_write_w  <= 1'b0;
      mem_to_reg_w <= 1'b0;
      jal_w        <= 1'b0;
      read_data_w  <= '0;
      alu_out_w    <= '0;
      write_reg_w  <= '0;
    end else if (flush) begin
      reg_write_w  <= 1'b0;
      mem_to_reg_w <= 1'b0;
      jal_w        <= 1'b0;
      read_data_w  <= '0;
      alu_out_w    <= '0;
      write_reg_w  <= '0;
    end else if (!stall_w) begin
      reg_write_w  <= reg_write_m;
      mem_to_reg_w <= mem_to_reg_m;
      jal_w        <= jal_m;
      read_data_w  <= read_data_m;
      alu_out_w    <= alu_out_m;
      write_reg_w  <= write_reg_m;
    end
  end

endmodule

// File: tb/tb_reg_w.sv
// ---------------------------------------------------------------------------
// tb_reg_w : self-checking bench for reg_w.
// The reference model is a single snapshot of "what write-back should see".
// It is updated once per rising edge from the pipeline rules: reset empties
// it, flush empties it, stall keeps it, otherwise it takes the inputs.
// ---------------------------------------------------------------------------
module tb_reg_w;

  localparam int DATA_W     = 32;
  localparam int REG_ADDR_W = 5;
  localparam int VEC_W      = 3 + 2 * DATA_W + REG_ADDR_W;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  stall_w;
`ifdef REG_W_FLUSH_EN
  logic                  flush_w;
`endif
  logic                  reg_write_m, mem_to_reg_m, jal_m;
  logic [DATA_W-1:0]     read_data_m, alu_out_m;
  logic [REG_ADDR_W-1:0] write_reg_m;
  logic                  reg_write_w, mem_to_reg_w, jal_w;
  logic [DATA_W-1:0]     read_data_w, alu_out_w;
  logic [REG_ADDR_W-1:0] write_reg_w;

  int checks = 0;
  int errors = 0;
  logic [VEC_W-1:0] exp_vec = '0;
  logic [VEC_W-1:0] prev_vec;

  always #5 clk = ~clk;

  reg_w #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .stall_w      (stall_w),
`ifdef REG_W_FLUSH_EN
    .flush_w      (flush_w),
`endif
    .reg_write_m  (reg_write_m),
    .mem_to_reg_m (mem_to_reg_m),
    .jal_m        (jal_m),
    .read_data_m  (read_data_m),
    .alu_out_m    (alu_out_m),
    .write_reg_m  (write_reg_m),
    .reg_write_w  (reg_write_w),
    .mem_to_reg_w (mem_to_reg_w),
    .jal_w        (jal_w),
    .read_data_w  (read_data_w),
    .alu_out_w    (alu_out_w),
    .write_reg_w  (write_reg_w)
  );

  function automatic logic [VEC_W-1:0] in_vec();
    return {reg_write_m, mem_to_reg_m, jal_m, read_data_m, alu_out_m, write_reg_m};
  endfunction

  function automatic logic [VEC_W-1:0] out_vec();
    return {reg_write_w, mem_to_reg_w, jal_w, read_data_w, alu_out_w, write_reg_w};
  endfunction

  task automatic drive_random();
    reg_write_m  = 1'($urandom);
    mem_to_reg_m = 1'($urandom);
    jal_m        = 1'($urandom);
    read_data_m  = $urandom;
    alu_out_m    = $urandom;
    write_reg_m  = REG_ADDR_W'($urandom);
  endtask

  // Apply the model's rule for the coming edge, then return on the falling
  // edge so the outputs are sampled well away from the capture edge.
  task automatic tick();
    logic fl;
    fl = 1'b0;
`ifdef REG_W_FLUSH_EN
    fl = flush_w;
`endif
    if (rst || fl)     exp_vec = '0;
    else if (!stall_w) exp_vec = in_vec();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; stall_w = 1'b0;
`ifdef REG_W_FLUSH_EN
    flush_w = 1'b0;
`endif
    drive_random();
    reg_write_m = 1'b1; read_data_m = 32'hFFFF_FFFF;
    tick();
    checks++;
    if (out_vec() !== exp_vec) begin
      errors++; $display("FAIL preload got=%h exp=%h", out_vec(), exp_vec);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (out_vec() !== '0) begin
      errors++; $display("FAIL reset_async got=%h exp=0", out_vec());
    end
    for (int i = 0; i < 2; i++) begin
      drive_random();
      tick();
      checks++;
      if (out_vec() !== exp_vec) begin
        errors++; $display("FAIL reset_held[%0d] got=%h exp=%h", i, out_vec(), exp_vec);
      end
    end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_basic_capture();
    reg_write_m = 1'b1; mem_to_reg_m = 1'b1; jal_m = 1'b1;
    read_data_m = 32'h0000_000F; alu_out_m = 32'h0000_000C; write_reg_m = 5'h0A;
    tick();
    checks++;
    if (out_vec() !== {1'b1, 1'b1, 1'b1, 32'h0000_000F, 32'h0000_000C, 5'h0A}) begin
      errors++; $display("FAIL basic_capture got=%h", out_vec());
    end
    $display("test_basic_capture done");
  endtask

  task automatic test_mid_cycle();
    prev_vec = out_vec();
    #2;
    mem_to_reg_m = 1'b0; read_data_m = 32'h0234_0000;
    alu_out_m = 32'h0000_6790; write_reg_m = 5'h11;
    #1;
    checks++;
    if (out_vec() !== {1'b1, 1'b1, 1'b1, 32'h0000_000F, 32'h0000_000C, 5'h0A}) begin
      errors++; $display("FAIL mid_cycle_hold got=%h exp=%h", out_vec(), prev_vec);
    end
    tick();
    checks++;
    if (out_vec() !== {1'b1, 1'b0, 1'b1, 32'h0234_0000, 32'h0000_6790, 5'h11}) begin
      errors++; $display("FAIL mid_cycle_update got=%h", out_vec());
    end
    $display("test_mid_cycle done");
  endtask

  task automatic test_stall();
    drive_random();
    tick();
    prev_vec = exp_vec;
    checks++;
    if (out_vec() !== exp_vec) begin
      errors++; $display("FAIL stall_load got=%h exp=%h", out_vec(), exp_vec);
    end
    stall_w = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive_random();
      reg_write_m = ~prev_vec[VEC_W-1];
      tick();
      checks++;
      if (out_vec() !== prev_vec) begin
        errors++; $display("FAIL stall_hold[%0d] got=%h exp=%h", i, out_vec(), prev_vec);
      end
    end
    stall_w = 1'b0;
    tick();
    checks++;
    if (out_vec() !== exp_vec || exp_vec === prev_vec) begin
      errors++; $display("FAIL stall_release got=%h exp=%h", out_vec(), exp_vec);
    end
    $display("test_stall done");
  endtask

  task automatic test_async_reset_mid();
    drive_random();
    reg_write_m = 1'b1; alu_out_m = 32'hDEAD_BEEF;
    tick();
    checks++;
    if (out_vec() !== exp_vec) begin
      errors++; $display("FAIL arst_load got=%h exp=%h", out_vec(), exp_vec);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (out_vec() !== '0) begin
      errors++; $display("FAIL arst_drop got=%h exp=0", out_vec());
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (out_vec() !== '0) begin
      errors++; $display("FAIL arst_after_release got=%h exp=0", out_vec());
    end
    drive_random();
    tick();
    checks++;
    if (out_vec() !== exp_vec) begin
      errors++; $display("FAIL arst_resume got=%h exp=%h", out_vec(), exp_vec);
    end
    $display("test_async_reset_mid done");
  endtask

  task automatic test_boundaries();
    reg_write_m = 1'b1; mem_to_reg_m = 1'b0; jal_m = 1'b0;
    read_data_m = '1; alu_out_m = 32'h8000_0000; write_reg_m = '0;
    tick();
    checks++;
    if (out_vec() !== {1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h8000_0000, 5'h00}) begin
      errors++; $display("FAIL boundary_zero_reg got=%h", out_vec());
    end
    reg_write_m = 1'b0; mem_to_reg_m = 1'b1; jal_m = 1'b1;
    read_data_m = '0; alu_out_m = 32'h7FFF_FFFF; write_reg_m = '1;
    tick();
    checks++;
    if (out_vec() !== {1'b0, 1'b1, 1'b1, 32'h0000_0000, 32'h7FFF_FFFF, 5'h1F}) begin
      errors++; $display("FAIL boundary_ones_reg got=%h", out_vec());
    end
    $display("test_boundaries done");
  endtask

`ifdef REG_W_FLUSH_EN
  task automatic test_flush();
    drive_random();
    reg_write_m = 1'b1;
    tick();
    stall_w = 1'b1; flush_w = 1'b1;
    drive_random();
    tick();
    checks++;
    if (out_vec() !== '0) begin
      errors++; $display("FAIL flush_over_stall got=%h exp=0", out_vec());
    end
    stall_w = 1'b0; flush_w = 1'b0;
    drive_random();
    tick();
    checks++;
    if (out_vec() !== exp_vec) begin
      errors++; $display("FAIL flush_resume got=%h exp=%h", out_vec(), exp_vec);
    end
    $display("test_flush done");
  endtask
`endif

  task automatic test_back_to_back();
    for (int i = 0; i < 60; i++) begin
      drive_random();
      stall_w = ($urandom_range(0, 3) == 0);
`ifdef REG_W_FLUSH_EN
      flush_w = ($urandom_range(0, 7) == 0);
`endif
      tick();
      checks++;
      if (out_vec() !== exp_vec) begin
        errors++; $display("FAIL b2b[%0d] got=%h exp=%h", i, out_vec(), exp_vec);
      end
      $display("b2b %0d stall=%0d out=%h", i, stall_w, out_vec());
    end
    stall_w = 1'b0;
`ifdef REG_W_FLUSH_EN
    flush_w = 1'b0;
`endif
  endtask

  initial begin
    test_reset();
    test_basic_capture();
    test_mid_cycle();
    test_stall();
    test_async_reset_mid();
    test_boundaries();
`ifdef REG_W_FLUSH_EN
    test_flush();
`endif
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_w.md
Name: reg_w

Overview:
- MEM→WB pipeline register of the 5-stage MIPS CPU.
- Captures the memory-stage control bits, memory read data, ALU result and destination register number on each rising clock edge.
- Presents them to the write-back stage one cycle later.
- Purely sequential: no combinational path from any input to any output.

Parameters:
- DATA_W, 32, width of the read-data and ALU-result paths.
- REG_ADDR_W, 5, width of the destination register number.

Ports:
- clk  input  1  system clock; all capture on rising edge.
- rst  input  1  asynchronous active-high reset.
- stall_w  input  1  hold: when 1, all outputs keep their current value.
- reg_write_m  input  1  register-file write enable from MEM.
- mem_to_reg_m  input  1  write-back mux select from MEM (1 = memory data).
- jal_m  input  1  jump-and-link marker from MEM (selects PC+8 write-back upstream).
- read_data_m  input  DATA_W  data-memory read result.
- alu_out_m  input  DATA_W  ALU result / memory address.
- write_reg_m  input  REG_ADDR_W  destination register number.
- reg_write_w  output  1  registered reg_write_m.
- mem_to_reg_w  output  1  registered mem_to_reg_m.
- jal_w  output  1  registered jal_m.
- read_data_w  output  DATA_W  registered read_data_m.
- alu_out_w  output  DATA_W  registered alu_out_m.
- write_reg_w  output  REG_ADDR_W  registered write_reg_m.

Behaviour:
- Reset:
  - rst=1 immediately (no clock needed) forces every output to 0.
  - All-zero reset state is a bubble: reg_write_w=0, so nothing is written.
  - Outputs stay 0 while rst is held.
  - On the first rising edge after rst falls, normal capture resumes.
  - rst asserted mid-operation discards the held contents.
- Capture:
  - On rising clk with rst=0 and stall_w=0, every output takes its corresponding input value sampled at that edge.
  - Latency exactly 1 cycle.
  - Input changes between edges are invisible at the outputs until the next rising edge.
- Stall:
  - On rising clk with stall_w=1 and rst=0, all outputs hold.
  - The stall applies to the whole register; no field updates independently.
- Precedence: rst > flush (if compiled in) > stall_w > capture.
- Width rules:
  - Fields are copied bit-exact; no sign extension or truncation.
  - write_reg_m value 0 is passed through unchanged. Register-0 suppression is the register file's job.
- Unknown/undriven inputs propagate as-is; no X-masking.
- The register uses no falling-edge logic.

Optional Feature:
- Macro REG_W_FLUSH_EN.
- Defined:
  - Adds input port flush_w (1 bit), placed after stall_w.
  - On rising clk with rst=0 and flush_w=1, all outputs are cleared to 0 (bubble), regardless of stall_w.
- Undefined:
  - No flush_w port exists.
  - Behaviour is exactly as above.

Test Plan:
- Reset: assert rst with arbitrary inputs (read_data_m=32'hFFFF_FFFF) -> all outputs 0 immediately, without a clock edge; they remain 0 across two rising edges while rst=1.
- Basic capture: drive reg_write_m=1, mem_to_reg_m=1, jal_m=1, read_data_m=32'h0000000F, alu_out_m=32'h0000000C, write_reg_m=5'h0A before an edge -> after that edge outputs are 1,1,1, 32'h0000000F, 32'h0000000C, 5'h0A.
- Mid-cycle change: change to mem_to_reg_m=0, read_data_m=32'h02340000, alu_out_m=32'h00006790, write_reg_m=5'h11 between edges -> outputs unchanged until the next rising edge, then show 0, 32'h02340000, 32'h00006790, 5'h11; reg_write_w and jal_w stay 1.
- Stall: load a value, then set stall_w=1 and change all inputs to new values for 3 edges -> outputs keep the old value; after stall_w=0 they update on the next edge.
- Async reset mid-operation: pulse rst between edges while outputs are non-zero -> outputs drop to 0 before the next edge; capture resumes on the first edge after release.
- Flush (REG_W_FLUSH_EN defined): with stall_w=1 and flush_w=1 at an edge -> all outputs 0. Without the macro, confirm the build has no flush_w port.
